// File: rtl/relogio_pkg.sv
// Shared clock-domain types: adjustment modes, field limits and wrap helpers.
// Also used by the display block.
package relogio_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    AJ_HORAS = 2'b01,
    AJ_MIN   = 2'b10,
    AJ_SEG   = 2'b11
  } modo_t;

  localparam logic [5:0] MAX_SEG  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HORA = 6'd23;

  // Out-of-range inputs are pulled back into range so a field can never escape it.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] max_v);
    return (v == 6'd0 || v > max_v) ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/botao_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter and rising-edge press pulse.
// A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module botao_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             nivel;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      nivel   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (sync_p1 == nivel) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        nivel <= sync_p1;
        press <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// Clock/time-set controller: mode FSM, 1 Hz divider and HH:MM:SS registers.
// Time runs only in NORMAL; the AJ_* modes freeze it and edit one field.
module relogio_ajuste_ctrl
  import relogio_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_modo,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [5:0] segundos,
  output logic [5:0] minutos,
  output logic [5:0] horas,
  output logic [1:0] modo_ajuste
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

  modo_t            modo;
  modo_t            modo_next;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             press_modo;
  logic             press_inc;
  logic             press_dec;
  logic             ajuste_ok;

  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_modo (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_raw(btn_modo), .press(press_modo)
  );
  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_raw(btn_inc), .press(press_inc)
  );
  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_raw(btn_dec), .press(press_dec)
  );

  assign modo_ajuste = modo;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) modo <= NORMAL;
    else        modo <= modo_next;
  end

  always_comb begin
    modo_next = modo;
    if (press_modo) begin
      case (modo)
        NORMAL:   modo_next = AJ_HORAS;
        AJ_HORAS: modo_next = AJ_MIN;
        AJ_MIN:   modo_next = AJ_SEG;
        default:  modo_next = NORMAL;
      endcase
    end
  end

  // Divider is pinned to 0 outside NORMAL so a return to NORMAL waits a full period.
  assign tick = (modo == NORMAL) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset)                          div_cnt <= '0;
    else if (modo != NORMAL || tick)     div_cnt <= '0;
    else                                 div_cnt <= div_cnt + 1'b1;
  end

  // A mode press wins over inc/dec, and simultaneous inc+dec cancel out.
  assign ajuste_ok = !press_modo && (press_inc ^ press_dec);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      segundos <= '0;
      minutos  <= '0;
      horas    <= '0;
    end else if (tick) begin
      segundos <= inc_wrap(segundos, MAX_SEG);
      if (segundos >= MAX_SEG) begin
        minutos <= inc_wrap(minutos, MAX_MIN);
        if (minutos >= MAX_MIN) horas <= inc_wrap(horas, MAX_HORA);
      end
    end else if (ajuste_ok) begin
      case (modo)
        AJ_HORAS: horas    <= press_inc ? inc_wrap(horas, MAX_HORA)   : dec_wrap(horas, MAX_HORA);
        AJ_MIN:   minutos  <= press_inc ? inc_wrap(minutos, MAX_MIN)  : dec_wrap(minutos, MAX_MIN);
        AJ_SEG:   segundos <= press_inc ? inc_wrap(segundos, MAX_SEG) : dec_wrap(segundos, MAX_SEG);
        default:  ;
      endcase
    end
  end

endmodule

// File: doc/relogio_ajuste_ctrl.md
RELOGIO_AJUSTE_CTRL -- requirements
Module: relogio_ajuste_ctrl

Interface
REQ-001 Parameter CLK_FREQ SHALL default to 100_000_000; it sets clock cycles per 1 Hz tick.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 1_000_000 (10 ms); it sets the stable-input cycles required before a button level is accepted.
REQ-003 Port clk_100MHz, input, 1 bit: the single system clock.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port btn_modo, input, 1 bit: raw, asynchronous mode-advance button.
REQ-006 Port btn_inc, input, 1 bit: raw, asynchronous increment button.
REQ-007 Port btn_dec, input, 1 bit: raw, asynchronous decrement button.
REQ-008 Port segundos, output, 6 bits: seconds, 0..59.
REQ-009 Port minutos, output, 6 bits: minutes, 0..59.
REQ-010 Port horas, output, 6 bits: hours, 0..23.
REQ-011 Port modo_ajuste, output, 2 bits: current mode, consumed by the display block.

Function
REQ-012 Each button SHALL pass through a 2-FF synchronizer and a debounce counter; the accepted level SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-013 A rising edge of an accepted level SHALL produce a single-cycle press pulse; releases SHALL produce nothing, and holding a button SHALL not auto-repeat.
REQ-014 The mode FSM SHALL have four states, encoded on modo_ajuste: NORMAL=00, AJ_HORAS=01, AJ_MIN=10, AJ_SEG=11.
REQ-015 A modo press SHALL advance the FSM NORMAL->AJ_HORAS->AJ_MIN->AJ_SEG->NORMAL; the new mode SHALL appear on modo_ajuste the cycle after the pulse.
REQ-016 A tick divider SHALL count 0..CLK_FREQ-1 and emit a 1-cycle tick on the terminal count, then wrap to 0; it SHALL count only in NORMAL.
REQ-017 In NORMAL, each tick SHALL increment segundos; 59 SHALL wrap to 0 and carry into minutos; minutos 59 SHALL wrap and carry into horas; 23:59:59 SHALL become 00:00:00.
REQ-018 In NORMAL, inc and dec presses SHALL be ignored.
REQ-019 In an AJ_* state, the time SHALL be frozen, and the tick divider SHALL be held at 0.
REQ-020 In an AJ_* state, an inc press SHALL add 1 to the selected field only, with wrap (horas 23->0; minutos or segundos 59->0) and no carry to other fields.
REQ-021 In an AJ_* state, a dec press SHALL subtract 1 from the selected field only, with wrap (horas 0->23; minutos or segundos 0->59) and no borrow.
REQ-022 A field update SHALL be visible on the output the cycle after the press pulse (1-cycle latency).
REQ-023 If inc and dec pulses occur in the same cycle, both SHALL be ignored.
REQ-024 If a modo pulse coincides with an inc or dec pulse, the mode change SHALL take effect and the inc/dec SHALL be ignored.
REQ-025 On return to NORMAL, the divider SHALL restart from 0, so the first tick comes CLK_FREQ cycles later.
REQ-026 All outputs SHALL be driven directly from registers.
REQ-027 Field values SHALL never leave their legal ranges.

Reset
REQ-028 While reset=0, regardless of clock: segundos, minutos and horas SHALL be 0; modo_ajuste SHALL be NORMAL; the divider SHALL be 0; and synchronizer, debounce and edge state SHALL be cleared (accepted level 0).
REQ-029 After reset is deasserted, a button already held SHALL produce exactly one press, once debounce completes.
REQ-030 Reset asserted mid-adjustment SHALL discard the adjustment and return to NORMAL at 00:00:00.

Structure
REQ-031 Package relogio_pkg SHALL hold the modo_t enum (NORMAL, AJ_HORAS, AJ_MIN, AJ_SEG) and the constants MAX_SEG=59, MAX_MIN=59, MAX_HORA=23, shared with the display block.
REQ-032 Sub-module botao_debounce, with parameter DEBOUNCE_CYCLES and ports clk_100MHz, reset, btn_raw and press, SHALL be instantiated three times.
REQ-033 The FSM, divider and time registers SHALL reside in relogio_ajuste_ctrl.

Verification (CLK_FREQ=10, DEBOUNCE_CYCLES=4)
REQ-034 Release reset, apply no buttons, run 10*86400 cycles: the time SHALL go 00:00:00 -> 23:59:59 -> 00:00:00 with the correct carries.
REQ-035 Bounce btn_modo 3 cycles high, 1 low, then hold high 6 cycles: exactly one modo change SHALL occur, 00->01.
REQ-036 In AJ_HORAS from horas=23, press inc -> horas=0 with minutos unchanged; press dec twice -> horas=22.
REQ-037 In AJ_SEG with segundos=0 and minutos=5, press dec -> segundos=59 with minutos=5; hold 50 cycles -> no tick advance occurs.
REQ-038 Assert inc and dec simultaneously in AJ_MIN -> no change; assert modo and inc simultaneously in AJ_MIN -> mode 11 with minutos unchanged.
REQ-039 Assert reset asynchronously mid-cycle while in AJ_MIN at 12:34:56 -> all outputs 0 and modo_ajuste=00 before the next clock edge.
